// File: rtl/pc_fetch_unit_pkg.sv
// Shared widths, reset values and decoder opcode encodings for the PIC16C5x fetch stage.
package pc_fetch_unit_pkg;

  localparam int unsigned INST_WIDTH = 12;
  localparam int unsigned PC_WIDTH   = 9;
  localparam int unsigned ALU_WIDTH  = 8;
  localparam int unsigned DEPTH_W    = 2;

  localparam logic [PC_WIDTH-1:0]   RESET_VECTOR = 9'h1FF;
  localparam logic [INST_WIDTH-1:0] NOP_INST     = 12'h000;

  // Opcode match patterns the decoder uses to raise goto/call/retlw enables.
  localparam logic [INST_WIDTH-1:0] OP_GOTO_MASK  = 12'hE00;
  localparam logic [INST_WIDTH-1:0] OP_GOTO       = 12'hA00;
  localparam logic [INST_WIDTH-1:0] OP_CALL_MASK  = 12'hF00;
  localparam logic [INST_WIDTH-1:0] OP_CALL       = 12'h900;
  localparam logic [INST_WIDTH-1:0] OP_RETLW_MASK = 12'hF00;
  localparam logic [INST_WIDTH-1:0] OP_RETLW      = 12'h800;

  typedef enum logic [2:0] {
    NPC_INC   = 3'd0,
    NPC_SKIP  = 3'd1,
    NPC_PCL   = 3'd2,
    NPC_GOTO  = 3'd3,
    NPC_CALL  = 3'd4,
    NPC_RET   = 3'd5
  } npc_sel_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: program memory data, decoder redirects, and fetch outputs.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic                  hold;
  logic [INST_WIDTH-1:0] inst;
  logic                  goto_en;
  logic                  call_en;
  logic                  ret_en;
  logic                  pcl_wr_en;
  logic                  skip_en;
  logic [PC_WIDTH-1:0]   jump_addr;
  logic [ALU_WIDTH-1:0]  alu_out;
  logic [PC_WIDTH-1:0]   pc;
  logic [INST_WIDTH-1:0] ir;
  logic                  stack_overflow;

  modport master (
    output hold, inst, goto_en, call_en, ret_en, pcl_wr_en, skip_en, jump_addr, alu_out,
    input  pc, ir, stack_overflow
  );

  modport slave (
    input  hold, inst, goto_en, call_en, ret_en, pcl_wr_en, skip_en, jump_addr, alu_out,
    output pc, ir, stack_overflow
  );
endinterface

// File: rtl/pc_fetch_unit_stack2.sv
// Two-level hardware return stack with depth tracking and sticky overflow flag.
module pc_stack2
  import pc_fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                overflow
);

  logic [PC_WIDTH-1:0] stack1;
  logic [PC_WIDTH-1:0] stack2;
  logic [DEPTH_W-1:0]  depth;

  // Pop wins over push; stack2 is retained on pop so a shallow return repeats it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stack1   <= '0;
      stack2   <= '0;
      depth    <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      if (pop) begin
        stack1 <= stack2;
        if (depth != '0) depth <= depth - DEPTH_W'(1);
      end else if (push) begin
        stack2 <= stack1;
        stack1 <= push_data;
        if (depth == DEPTH_W'(2)) overflow <= 1'b1;
        else                      depth    <= depth + DEPTH_W'(1);
      end
    end
  end

  assign top = stack1;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, next-PC redirect mux, instruction register and return stack.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  pc_fetch_unit_if.slave bus
);

  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [INST_WIDTH-1:0] ir_q;
  logic [INST_WIDTH-1:0] ir_d;
  logic [PC_WIDTH-1:0]   stack_top;
  logic                  overflow;
  npc_sel_e              sel;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  // Redirect priority: return, call, goto, PCL write, skip, sequential.
  always_comb begin
    sel = NPC_INC;
    if      (bus.ret_en)    sel = NPC_RET;
    else if (bus.call_en)   sel = NPC_CALL;
    else if (bus.goto_en)   sel = NPC_GOTO;
    else if (bus.pcl_wr_en) sel = NPC_PCL;
    else if (bus.skip_en)   sel = NPC_SKIP;
  end

  // Any non-sequential select squashes the already-fetched word.
  always_comb begin
    pc_d = pc_inc;
    ir_d = NOP_INST;
    unique case (sel)
      NPC_RET:  pc_d = stack_top;
      NPC_CALL: pc_d = {1'b0, bus.jump_addr[7:0]};
      NPC_GOTO: pc_d = bus.jump_addr;
      NPC_PCL:  pc_d = {1'b0, bus.alu_out};
      NPC_SKIP: pc_d = pc_inc;
      default: begin
        pc_d = pc_inc;
        ir_d = bus.inst;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
      ir_q <= NOP_INST;
    end else if (!bus.hold) begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  pc_stack2 u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (!bus.hold),
    .push      (sel == NPC_CALL),
    .pop       (sel == NPC_RET),
    .push_data (pc_q),
    .top       (stack_top),
    .overflow  (overflow)
  );

  assign bus.pc             = pc_q;
  assign bus.ir             = ir_q;
  assign bus.stack_overflow = overflow;

endmodule
